stream_lane_compositor: RTL and testbench



---
 rtl/stream_lane_compositor_if.sv | 44 ++++
 rtl/stream_lane_compositor.sv | 147 ++++++++++++++
 tb/tb_stream_lane_compositor.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/stream_lane_compositor_if.sv
// Command and drain handshakes of the lane compositor bundled into one interface.
// STREAM_LANE_FLIP_X_EN adds the per-command i_flip_x signal.
interface stream_lane_compositor_if #(
    parameter int LANES   = 16,
    parameter int X_W     = 8,
    parameter int TEX_W   = 16,
    parameter int COLOR_W = 8,
    parameter int Z_W     = 8
);
    localparam int IDX_W = $clog2(LANES);

    logic                     i_cmd_valid;
    logic                     o_cmd_ready;
    logic [TEX_W*COLOR_W-1:0] i_texture_data;
    logic [X_W-1:0]           i_start_x;
    logic [Z_W-1:0]           i_position_z;
    logic                     i_cmd_last;
`ifdef STREAM_LANE_FLIP_X_EN
    logic                     i_flip_x;
`endif
    logic                     o_pix_valid;
    logic                     i_pix_ready;
    logic [COLOR_W-1:0]       o_pix_color;
    logic [IDX_W-1:0]         o_pix_index;
    logic                     o_pix_last;

    modport master (
        output i_cmd_valid, i_texture_data, i_start_x, i_position_z, i_cmd_last,
`ifdef STREAM_LANE_FLIP_X_EN
        output i_flip_x,
`endif
        output i_pix_ready,
        input  o_cmd_ready, o_pix_valid, o_pix_color, o_pix_index, o_pix_last
    );

    modport slave (
        input  i_cmd_valid, i_texture_data, i_start_x, i_position_z, i_cmd_last,
`ifdef STREAM_LANE_FLIP_X_EN
        input  i_flip_x,
`endif
        input  i_pix_ready,
        output o_cmd_ready, o_pix_valid, o_pix_color, o_pix_index, o_pix_last
    );
endinterface

// File: rtl/stream_lane_compositor.sv
// Row compositor: depth-tests sprite rows against LANES pixel lanes, then drains the row serially.
// Optional horizontal texel flip per command is enabled with STREAM_LANE_FLIP_X_EN.
module stream_lane_compositor #(
    parameter int LANES       = 16,
    parameter int BASE_X      = 0,
    parameter int X_W         = 8,
    parameter int TEX_W       = 16,
    parameter int COLOR_W     = 8,
    parameter int Z_W         = 8,
    parameter int TRANSPARENT = 255,
    parameter int CLEAR_COLOR = 0
) (
    input logic                    clk,
    input logic                    reset_n,
    stream_lane_compositor_if.slave bus
);
    localparam int                 IDX_W    = $clog2(LANES);
    localparam logic [COLOR_W-1:0] KEY      = COLOR_W'(TRANSPARENT);
    localparam logic [COLOR_W-1:0] CLEAR    = COLOR_W'(CLEAR_COLOR);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic {ACCEPT, DRAIN} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         counter;
    logic                     pix_valid;
    logic                     pix_last;

    logic                     s1_valid;
    logic                     s1_last;
    logic [TEX_W*COLOR_W-1:0] s1_data;
    logic [X_W-1:0]           s1_start_x;
    logic [Z_W-1:0]           s1_z;
    logic                     s1_flip;

    logic [Z_W-1:0]           lane_z     [LANES];
    logic [COLOR_W-1:0]       lane_color [LANES];
    logic [COLOR_W-1:0]       lane_texel [LANES];
    logic [LANES-1:0]         lane_we;

    logic                     cmd_ready;
    logic                     cmd_fire;

    // A pending "last" in stage 1 blocks intake so nothing slips in ahead of the drain.
    assign cmd_ready = (state == ACCEPT) && !(s1_valid && s1_last);
    assign cmd_fire  = bus.i_cmd_valid && cmd_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam logic [X_W-1:0] LANE_X = X_W'(BASE_X + g);
        logic [X_W:0] off_full;
        int           off;
        int           tex_idx;
        logic         hit;

        // The extra top bit is the borrow: a start_x right of this lane never wraps into a hit.
        assign off_full = {1'b0, LANE_X} - {1'b0, s1_start_x};
        assign off      = int'(off_full[X_W-1:0]);
        assign hit      = !off_full[X_W] && (off < TEX_W);
        assign tex_idx  = !hit ? 0 : (s1_flip ? (TEX_W - 1 - off) : off);

        assign lane_texel[g] = s1_data[tex_idx*COLOR_W +: COLOR_W];
        assign lane_we[g]    = hit && (s1_z >= lane_z[g])
                               && ((s1_z == '0) || (lane_texel[g] != KEY));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ACCEPT;
            counter    <= '0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_data    <= '0;
            s1_start_x <= '0;
            s1_z       <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane_z[i]     <= '0;
                lane_color[i] <= CLEAR;
            end
        end else begin
            s1_valid <= cmd_fire;
            if (cmd_fire) begin
                s1_last    <= bus.i_cmd_last;
                s1_data    <= bus.i_texture_data;
                s1_start_x <= bus.i_start_x;
                s1_z       <= bus.i_position_z;
            end

            case (state)
                ACCEPT: begin
                    if (s1_valid) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (lane_we[i]) begin
                                lane_color[i] <= lane_texel[i];
                                lane_z[i]     <= s1_z;
                            end
                        end
                        if (s1_last) begin
                            state     <= DRAIN;
                            counter   <= '0;
                            pix_valid <= 1'b1;
                            pix_last  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.i_pix_ready) begin
                        if (pix_last) begin
                            state     <= ACCEPT;
                            counter   <= '0;
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            for (int i = 0; i < LANES; i++) begin
                                lane_z[i]     <= '0;
                                lane_color[i] <= CLEAR;
                            end
                        end else begin
                            counter  <= counter + 1'b1;
                            pix_last <= ((counter + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end

`ifdef STREAM_LANE_FLIP_X_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_flip <= 1'b0;
        end else if (cmd_fire) begin
            s1_flip <= bus.i_flip_x;
        end
    end
`else
    assign s1_flip = 1'b0;
`endif

    assign bus.o_cmd_ready = cmd_ready;
    assign bus.o_pix_valid = pix_valid;
    assign bus.o_pix_index = counter;
    assign bus.o_pix_last  = pix_last;
    assign bus.o_pix_color = (state == DRAIN) ? lane_color[counter] : CLEAR;

endmodule

// File: tb/tb_stream_lane_compositor.sv
// Directed bench for stream_lane_compositor at default parameters (16 lanes, 8-bit colour/depth).
// The flip-x step runs only when STREAM_LANE_FLIP_X_EN is defined.
module tb_stream_lane_compositor;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    stream_lane_compositor_if bus ();

    stream_lane_compositor dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expColor [16];

    function automatic logic [127:0] texRamp();
        logic [127:0] t;
        for (int k = 0; k < 16; k++) t[k*8 +: 8] = 8'(k + 1);
        return t;
    endfunction

    function automatic logic [127:0] texFill(input logic [7:0] v);
        logic [127:0] t;
        for (int k = 0; k < 16; k++) t[k*8 +: 8] = v;
        return t;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic fillExp(input logic [7:0] v);
        for (int i = 0; i < 16; i++) expColor[i] = v;
    endtask

    // Present one command and hold it until the handshake edge has passed.
    task automatic applyStimulus(input logic [127:0] data, input logic [7:0] sx,
                                 input logic [7:0] z, input logic last);
        int n = 0;
        bus.i_cmd_valid    = 1'b1;
        bus.i_texture_data = data;
        bus.i_start_x      = sx;
        bus.i_position_z   = z;
        bus.i_cmd_last     = last;
        while (!bus.o_cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.o_cmd_ready) checkOutput("cmd_ready_timeout", 32'(bus.o_cmd_ready), 32'd1);
        @(posedge clk); #1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_last  = 1'b0;
    endtask

    // Called in the cycle after the last command's handshake; walks all 16 pixels.
    task automatic drainLine(input string tag, input int holdAt);
        checkOutput({tag, "_ready_lo"}, 32'(bus.o_cmd_ready), 32'd0);
        checkOutput({tag, "_valid_lag"}, 32'(bus.o_pix_valid), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            if (i == holdAt) begin
                bus.i_pix_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    checkOutput({tag, "_hold_idx"}, 32'(bus.o_pix_index), 32'(i));
                    checkOutput({tag, "_hold_col"}, 32'(bus.o_pix_color), 32'(expColor[i]));
                    checkOutput({tag, "_hold_vld"}, 32'(bus.o_pix_valid), 32'd1);
                    checkOutput({tag, "_hold_rdy"}, 32'(bus.o_cmd_ready), 32'd0);
                end
                bus.i_pix_ready = 1'b1;
            end
            checkOutput({tag, "_vld"}, 32'(bus.o_pix_valid), 32'd1);
            checkOutput({tag, "_idx"}, 32'(bus.o_pix_index), 32'(i));
            checkOutput({tag, "_col"}, 32'(bus.o_pix_color), 32'(expColor[i]));
            checkOutput({tag, "_last"}, 32'(bus.o_pix_last), 32'(i == 15));
            checkOutput({tag, "_rdy"}, 32'(bus.o_cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        checkOutput({tag, "_end_vld"}, 32'(bus.o_pix_valid), 32'd0);
        checkOutput({tag, "_end_rdy"}, 32'(bus.o_cmd_ready), 32'd1);
    endtask

    initial begin
        bus.i_cmd_valid    = 1'b0;
        bus.i_texture_data = '0;
        bus.i_start_x      = '0;
        bus.i_position_z   = '0;
        bus.i_cmd_last     = 1'b0;
        bus.i_pix_ready    = 1'b1;
`ifdef STREAM_LANE_FLIP_X_EN
        bus.i_flip_x       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_vld", 32'(bus.o_pix_valid), 32'd0);
        checkOutput("rst_idx", 32'(bus.o_pix_index), 32'd0);
        checkOutput("rst_last", 32'(bus.o_pix_last), 32'd0);
        checkOutput("rst_col", 32'(bus.o_pix_color), 32'd0);
        checkOutput("rst_rdy", 32'(bus.o_cmd_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] ramp row, then cleared line");
        applyStimulus(texRamp(), 8'd0, 8'd5, 1'b1);
        for (int i = 0; i < 16; i++) expColor[i] = 8'(i + 1);
        drainLine("t1", -1);
        applyStimulus(texRamp(), 8'd250, 8'd9, 1'b1);
        fillExp(8'h00);
        drainLine("t1_clr", -1);

        $display("[TB] depth ordering");
        applyStimulus(texFill(8'h10), 8'd0, 8'd3, 1'b0);
        applyStimulus(texFill(8'h20), 8'd0, 8'd2, 1'b1);
        fillExp(8'h10);
        drainLine("t2_near", -1);
        applyStimulus(texFill(8'h10), 8'd0, 8'd3, 1'b0);
        applyStimulus(texFill(8'h30), 8'd0, 8'd3, 1'b1);
        fillExp(8'h30);
        drainLine("t2_eq", -1);

        $display("[TB] transparency key");
        applyStimulus(texFill(8'h10), 8'd0, 8'd1, 1'b0);
        applyStimulus(texFill(8'hFF), 8'd0, 8'd4, 1'b1);
        fillExp(8'h10);
        drainLine("t3_key", -1);
        applyStimulus(texFill(8'hFF), 8'd0, 8'd0, 1'b1);
        fillExp(8'hFF);
        drainLine("t3_bg", -1);

        $display("[TB] bounds");
        applyStimulus(texRamp(), 8'd10, 8'd1, 1'b1);
        for (int i = 0; i < 16; i++) expColor[i] = (i < 10) ? 8'h00 : 8'(i - 9);
        drainLine("t4_part", -1);
        applyStimulus(texFill(8'h10), 8'd0, 8'd1, 1'b0);
        applyStimulus(texRamp(), 8'd250, 8'd9, 1'b1);
        fillExp(8'h10);
        drainLine("t4_nowrap", -1);

        $display("[TB] backpressure with a command waiting");
        applyStimulus(texRamp(), 8'd0, 8'd5, 1'b1);
        bus.i_cmd_valid    = 1'b1;
        bus.i_texture_data = texFill(8'h55);
        bus.i_start_x      = 8'd0;
        bus.i_position_z   = 8'd7;
        bus.i_cmd_last     = 1'b1;
        for (int i = 0; i < 16; i++) expColor[i] = 8'(i + 1);
        drainLine("t5", 7);
        @(posedge clk); #1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_last  = 1'b0;
        fillExp(8'h55);
        drainLine("t5_pend", -1);

        $display("[TB] reset mid-drain");
        applyStimulus(texRamp(), 8'd0, 8'd5, 1'b1);
        @(posedge clk); #1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        checkOutput("t6_pre_idx", 32'(bus.o_pix_index), 32'd4);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_vld", 32'(bus.o_pix_valid), 32'd0);
        checkOutput("t6_rst_rdy", 32'(bus.o_cmd_ready), 32'd1);
        checkOutput("t6_rst_idx", 32'(bus.o_pix_index), 32'd0);
        checkOutput("t6_rst_col", 32'(bus.o_pix_color), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("t6_quiet_vld", 32'(bus.o_pix_valid), 32'd0);
        end
        applyStimulus(texFill(8'h00), 8'd0, 8'd0, 1'b1);
        fillExp(8'h00);
        drainLine("t6_after", -1);

`ifdef STREAM_LANE_FLIP_X_EN
        $display("[TB] flip-x");
        bus.i_flip_x = 1'b1;
        applyStimulus(texRamp(), 8'd0, 8'd1, 1'b1);
        bus.i_flip_x = 1'b0;
        for (int i = 0; i < 16; i++) expColor[i] = 8'(16 - i);
        drainLine("t7_flip", -1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
